mem_port_responder: RTL and testbench

Memory-side responder for the multicycle CPU memory port. Services the `mem_read`/`mem_write` strobes the control FSM issues against the IorD-selected address. Backs the port with an internal word-addressed RAM. Models a configurable read latency with a busy/valid handshake so the control FSM can later add wait states for loads, stores and fetches.

---
 rtl/mem_port_responder.sv | 130 +++++++++++++
 tb/tb_mem_port_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_responder.sv
// Memory-side responder for the multicycle CPU memory port: word-addressed RAM
// with a configurable read latency and busy/valid/done/err handshake.
module mem_port_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        wdone,
  output logic        busy,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              wdone_q, wdone_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];

  logic              bad_c;
  logic [ADDR_W-1:0] req_idx_c;

  // Reject conflicting strobes, misaligned and out-of-range byte addresses
  assign bad_c = (mem_read && mem_write)
              || (addr[1:0] != 2'b00)
              || ((addr >> (ADDR_W + 2)) != 32'd0);
  assign req_idx_c = addr[ADDR_W+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdat_d   = wdat_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (bad_c) begin
            err_d = 1'b1;
          end else if (mem_read) begin
            idx_d   = req_idx_c;
            cnt_d   = CNT_W'(READ_LAT - 1);
            state_d = RD_WAIT;
          end else begin
            idx_d   = req_idx_c;
            wdat_d  = wdata;
            state_d = WR;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d  = mem[idx_q];
          rvalid_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WR: begin
        wdone_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wdat_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdat_q   <= wdat_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // RAM is not reset; an async reset during WR returns to IDLE before the commit edge
  always_ff @(posedge clk) begin
    if (state_q == WR) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign wdone  = wdone_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder: three instances (READ_LAT 2, 1, 15)
// driven by a vector table, a read-data scoreboard and hand-written corner sequences.
module tb_mem_port_responder;

  localparam int unsigned NDUT = 3;
  localparam int K_NONE = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read  [NDUT];
  logic        mem_write [NDUT];
  logic [31:0] addr      [NDUT];
  logic [31:0] wdata     [NDUT];
  logic [31:0] rdata     [NDUT];
  logic        rvalid    [NDUT];
  logic        wdone     [NDUT];
  logic        busy      [NDUT];
  logic        err       [NDUT];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic [31:0] d;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    int          kind;
    logic [31:0] want;
    string       name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_port_responder #(.ADDR_W(8), .READ_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .rvalid(rvalid[0]),
    .wdone(wdone[0]), .busy(busy[0]), .err(err[0]));

  mem_port_responder #(.ADDR_W(8), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .rvalid(rvalid[1]),
    .wdone(wdone[1]), .busy(busy[1]), .err(err[1]));

  mem_port_responder #(.ADDR_W(8), .READ_LAT(15)) u_lat15 (
    .clk(clk), .reset(reset), .mem_read(mem_read[2]), .mem_write(mem_write[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .rvalid(rvalid[2]),
    .wdone(wdone[2]), .busy(busy[2]), .err(err[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic int lat_of(input int k, input int kind);
    if (kind == K_ERR) return 0;
    if (kind == K_WR) return 1;
    if (k == 1) return 1;
    if (k == 2) return 15;
    return 2;
  endfunction

  // Read-data scoreboard: every rvalid pops the oldest expected read
  always @(negedge clk) begin
    sb_t e;
    for (int k = 0; k < int'(NDUT); k++) begin
      if (rvalid[k] === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_rvalid dut%0d: got rdata 0x%08h, expected no rvalid", k, rdata[k]);
        end else begin
          e = sbq.pop_front();
          check($sformatf("sb_dut%0d_owner", k), 32'(k), 32'(e.k));
          check($sformatf("sb_dut%0d_rdata", k), rdata[k], e.d);
        end
      end
    end
  end

  // Drive one request at a negedge, hold it until a response, check kind/latency/busy
  task automatic run_req(input int k, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int kind, input logic [31:0] want,
                         input string name);
    int n;
    int got;
    int bcnt;
    logic [31:0] prev;
    prev = rdata[k];
    if (kind == K_RD) sbq.push_back('{k, want});
    mem_read[k]  = rd;
    mem_write[k] = wr;
    addr[k]      = a;
    wdata[k]     = d;
    n = 0;
    got = K_NONE;
    bcnt = 0;
    while (got == K_NONE && n < 40) begin
      @(negedge clk);
      n++;
      if (busy[k] === 1'b1) bcnt++;
      if (rvalid[k] === 1'b1)     got = K_RD;
      else if (wdone[k] === 1'b1) got = K_WR;
      else if (err[k] === 1'b1)   got = K_ERR;
    end
    mem_read[k]  = 1'b0;
    mem_write[k] = 1'b0;
    check({name, "_kind"}, 32'(got), 32'(kind));
    if (got == kind) begin
      check({name, "_latency"}, 32'(n - 1), 32'(lat_of(k, kind)));
      check({name, "_busy_cycles"}, 32'(bcnt), 32'(lat_of(k, kind)));
    end
    if (kind == K_ERR) begin
      check({name, "_rdata_kept"}, rdata[k], prev);
      check({name, "_not_busy"}, 32'(busy[k]), 32'd0);
    end
  endtask

  initial begin
    int bad;
    int wd;

    for (int k = 0; k < int'(NDUT); k++) begin
      mem_read[k] = 1'b0; mem_write[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end

    // Async reset asserted mid-cycle
    #3 reset = 1'b1;
    #1;
    for (int k = 0; k < int'(NDUT); k++) begin
      check($sformatf("reset_flags_dut%0d", k),
            {28'd0, rvalid[k], wdone[k], busy[k], err[k]}, 32'd0);
      check($sformatf("reset_rdata_dut%0d", k), rdata[k], 32'd0);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < int'(NDUT); k++)
        if ((rvalid[k] | wdone[k] | busy[k] | err[k]) !== 1'b0) bad++;
    end
    check("idle_after_reset", 32'(bad), 32'd0);

    vecs.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, K_WR,  32'h0, "init_w0"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000, K_WR,  32'h0, "init_w20"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0030, 32'h0000_0000, K_WR,  32'h0, "init_w30"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, K_WR,  32'h0, "wr_10"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, K_RD,  32'hDEAD_BEEF, "rd_10"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, K_ERR, 32'h0, "rd_misaligned"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h7777_7777, K_ERR, 32'h0, "wr_misaligned"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, K_ERR, 32'h0, "rd_out_of_range"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, K_ERR, 32'h0, "wr_out_of_range"});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, K_ERR, 32'h0, "both_strobes"});
    vecs.push_back('{1'b0, 1'b1, 32'h8000_0010, 32'h2222_2222, K_ERR, 32'h0, "wr_high_addr"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, K_RD,  32'hDEAD_BEEF, "rd_10_after_rejects"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, K_RD,  32'h0, "rd_0_after_rejects"});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, K_WR,  32'h0, "wr_last_word"});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, K_RD,  32'hA5A5_A5A5, "rd_last_word"});

    foreach (vecs[i])
      run_req(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].kind, vecs[i].want,
              vecs[i].name);

    // Latency sweep with back-to-back reads on READ_LAT=1 and READ_LAT=15
    for (int k = 1; k <= 2; k++) begin
      run_req(k, 1'b0, 1'b1, 32'h0000_000C, 32'h1234_5678, K_WR, 32'h0, $sformatf("sweep%0d_wr3", k));
      run_req(k, 1'b0, 1'b1, 32'h0000_0010, 32'h9ABC_DEF0, K_WR, 32'h0, $sformatf("sweep%0d_wr4", k));
      run_req(k, 1'b1, 1'b0, 32'h0000_000C, 32'h0, K_RD, 32'h1234_5678, $sformatf("sweep%0d_rd3", k));
      run_req(k, 1'b1, 1'b0, 32'h0000_0010, 32'h0, K_RD, 32'h9ABC_DEF0, $sformatf("sweep%0d_rd4", k));
    end

    // Write strobe while a read is in flight is ignored
    sbq.push_back('{0, 32'hDEAD_BEEF});
    mem_read[0] = 1'b1;
    addr[0]     = 32'h0000_0010;
    @(negedge clk);
    check("ignore_busy_high", 32'(busy[0]), 32'd1);
    mem_write[0] = 1'b1;
    addr[0]      = 32'h0000_0020;
    wdata[0]     = 32'hFFFF_FFFF;
    wd = 0;
    @(negedge clk);
    if (wdone[0] === 1'b1) wd++;
    mem_write[0] = 1'b0;
    @(negedge clk);
    check("ignore_rvalid", 32'(rvalid[0]), 32'd1);
    mem_read[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (wdone[0] === 1'b1 || err[0] === 1'b1) wd++;
    end
    check("ignore_no_wdone", 32'(wd), 32'd0);
    run_req(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, K_RD, 32'h0, "ignore_rd_20");

    // Reset between write acceptance and commit drops the write
    mem_write[0] = 1'b1;
    addr[0]      = 32'h0000_0030;
    wdata[0]     = 32'hCAFE_F00D;
    @(negedge clk);
    check("rstwr_accepted", 32'(busy[0]), 32'd1);
    mem_write[0] = 1'b0;
    reset = 1'b1;
    #1;
    check("rstwr_flags", {28'd0, rvalid[0], wdone[0], busy[0], err[0]}, 32'd0);
    check("rstwr_rdata", rdata[0], 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wd = 0;
    repeat (3) begin
      @(negedge clk);
      if (wdone[0] === 1'b1 || rvalid[0] === 1'b1) wd++;
    end
    check("rstwr_no_done", 32'(wd), 32'd0);
    run_req(0, 1'b1, 1'b0, 32'h0000_0030, 32'h0, K_RD, 32'h0, "rstwr_rd_30");

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
    $fatal(1);
  end

endmodule
